beta_mem_arbiter: RTL and testbench

Single-port main-memory arbiter and stall sequencer for the pipelined Beta. It shares one memory port between the IF-stage instruction fetch and the MEM-stage load/store port (addr/wd/mwr/moe). Data accesses have priority over fetches. The block holds each completed result until the pipeline advances, and drives the global `stall` that freezes the pipeline registers while any access is outstanding.

---
 rtl/beta_mem_arbiter.sv | 115 +++++++++++
 tb/tb_beta_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/beta_mem_arbiter.sv
// Single-port memory arbiter for the pipelined Beta: shares one memory port between
// instruction fetch and the MEM-stage load/store port, and generates the pipeline stall.
module beta_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq,
  input  logic [31:0] iaddr,
  output logic [31:0] idata,
  output logic        ivalid,
  input  logic        moe,
  input  logic        mwr,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        dvalid,
  output logic        stall,
  output logic        berr,
  output logic [31:0] ma,
  output logic [31:0] mwd,
  output logic        mre,
  output logic        mwe,
  input  logic [31:0] mdin,
  input  logic        mack
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          dreq;
  logic          timeout_hit;
  logic          done;

  // Memory handshake: an access is issued by raising mre or mwe with ma/mwd; all
  // four stay stable until the edge that samples mack=1, which completes it.
  assign dreq        = moe | mwr;
  assign stall       = (dreq & ~dvalid) | (ireq & ~ivalid);
  assign timeout_hit = ~mack && (cnt == CW'(TIMEOUT - 2));
  assign done        = mack | timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      ma     <= '0;
      mwd    <= '0;
      mre    <= 1'b0;
      mwe    <= 1'b0;
      rd     <= '0;
      idata  <= '0;
      ivalid <= 1'b0;
      dvalid <= 1'b0;
      berr   <= 1'b0;
    end else begin
      berr <= 1'b0;
      // Pipeline advance: held results have been consumed.
      if (!stall) begin
        ivalid <= 1'b0;
        dvalid <= 1'b0;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          if (dreq && !dvalid) begin
            ma    <= addr;
            mwd   <= wd;
            mwe   <= mwr;
            mre   <= ~mwr;
            state <= DATA;
          end else if (ireq && !ivalid) begin
            ma    <= iaddr;
            mre   <= 1'b1;
            mwe   <= 1'b0;
            state <= INST;
          end
        end
        DATA: begin
          if (done) begin
            mre    <= 1'b0;
            mwe    <= 1'b0;
            dvalid <= 1'b1;
            berr   <= ~mack;
            state  <= IDLE;
            // Stores leave the load result register untouched.
            if (!mwe) rd <= mack ? mdin : '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        INST: begin
          if (done) begin
            mre    <= 1'b0;
            mwe    <= 1'b0;
            ivalid <= 1'b1;
            berr   <= ~mack;
            idata  <= mack ? mdin : '0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Directed bench for beta_mem_arbiter: cycle checks in the stimulus block plus a
// scoreboard of expected rd/idata results popped when dvalid/ivalid rise.
module tb_beta_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        ireq;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        ivalid;
  logic        moe;
  logic        mwr;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        dvalid;
  logic        stall;
  logic        berr;
  logic [31:0] ma;
  logic [31:0] mwd;
  logic        mre;
  logic        mwe;
  logic [31:0] mdin;
  logic        mack;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  logic dv_q = 1'b0;
  logic iv_q = 1'b0;
  logic mre_q = 1'b0;
  int   data_issues = 0;

  beta_mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .idata(idata), .ivalid(ivalid),
    .moe(moe), .mwr(mwr), .addr(addr), .wd(wd), .rd(rd), .dvalid(dvalid),
    .stall(stall), .berr(berr),
    .ma(ma), .mwd(mwd), .mre(mre), .mwe(mwe), .mdin(mdin), .mack(mack)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) check({tag, "_underflow"}, 32'd1, 32'd0);
    else check(tag, obs, exp_q.pop_front());
  endtask

  // Scoreboard monitor on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      dv_q  <= 1'b0;
      iv_q  <= 1'b0;
      mre_q <= 1'b0;
    end else begin
      if (dvalid && !dv_q) sb_pop("sb_rd", rd);
      if (ivalid && !iv_q) sb_pop("sb_idata", idata);
      if (mre && !mre_q && ma == 32'h400) data_issues <= data_issues + 1;
      dv_q  <= dvalid;
      iv_q  <= ivalid;
      mre_q <= mre;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    ireq = 0; iaddr = 0; moe = 0; mwr = 0; addr = 0; wd = 0; mdin = 0; mack = 0;
  endtask

  initial begin
    logic [31:0] x1, x2;
    idle_inputs();
    reset = 1;
    step();
    step();
    check("rst_ma", ma, 0);
    check("rst_mre", {31'd0, mre}, 0);
    check("rst_mwe", {31'd0, mwe}, 0);
    check("rst_valids", {30'd0, ivalid, dvalid}, 0);
    check("rst_rd", rd, 0);
    check("rst_idata", idata, 0);
    check("rst_stall_berr", {30'd0, stall, berr}, 0);

    // reset mid-access
    reset = 0;
    moe = 1; addr = 32'h10;
    #1 check("r_stall_T", {31'd0, stall}, 1);
    step();
    check("r_ma", ma, 32'h10);
    check("r_mre", {31'd0, mre}, 1);
    reset = 1;
    step();
    check("r_mre_drop", {31'd0, mre}, 0);
    check("r_ma_clr", ma, 0);
    moe = 0; reset = 0; mack = 1; mdin = 32'hFFFF0000;
    step();
    check("r_ack_ignored", {30'd0, dvalid, mre}, 0);
    check("r_rd_zero", rd, 0);
    mack = 0;
    step();

    // lone fetch
    ireq = 1; iaddr = 32'h40;
    exp_q.push_back(32'h77FF0003);
    #1 check("f_stall_T", {31'd0, stall}, 1);
    step();
    check("f_ma", ma, 32'h40);
    check("f_mre", {31'd0, mre}, 1);
    check("f_stall_T1", {31'd0, stall}, 1);
    mack = 1; mdin = 32'h77FF0003;
    step();
    mack = 0;
    check("f_ivalid", {31'd0, ivalid}, 1);
    check("f_idata", idata, 32'h77FF0003);
    check("f_stall_T2", {31'd0, stall}, 0);
    check("f_mre_off", {31'd0, mre}, 0);
    ireq = 0;
    step();
    check("f_ivalid_clr", {31'd0, ivalid}, 0);

    // load + fetch collision
    moe = 1; addr = 32'h100; ireq = 1; iaddr = 32'h44;
    exp_q.push_back(32'hAA);
    exp_q.push_back(32'hBB);
    #1 check("c_stall_T", {31'd0, stall}, 1);
    step();
    check("c_ma_data", ma, 32'h100);
    check("c_strobes1", {30'd0, mre, mwe}, 2'b10);
    mack = 1; mdin = 32'hAA;
    step();
    mack = 0;
    check("c_dvalid", {31'd0, dvalid}, 1);
    check("c_rd", rd, 32'hAA);
    check("c_stall_T2", {31'd0, stall}, 1);
    check("c_mre_gap", {31'd0, mre}, 0);
    step();
    check("c_ma_inst", ma, 32'h44);
    check("c_mre_inst", {31'd0, mre}, 1);
    check("c_stall_T3", {31'd0, stall}, 1);
    mack = 1; mdin = 32'hBB;
    step();
    mack = 0;
    check("c_flags_T4", {30'd0, ivalid, dvalid}, 2'b11);
    check("c_idata", idata, 32'hBB);
    check("c_stall_T4", {31'd0, stall}, 0);
    idle_inputs();
    step();
    check("c_flags_T5", {30'd0, ivalid, dvalid}, 0);

    // store with a 3-cycle wait; rd must keep 0xAA
    mwr = 1; moe = 1; addr = 32'h200; wd = 32'hDEADBEEF;
    exp_q.push_back(32'hAA);
    for (int i = 0; i < 3; i++) begin
      step();
      check("s_strobes", {30'd0, mre, mwe}, 2'b01);
      check("s_mwd", mwd, 32'hDEADBEEF);
      check("s_ma", ma, 32'h200);
      check("s_dvalid_wait", {31'd0, dvalid}, 0);
      if (i == 2) begin
        mack = 1; mdin = 32'h12345678;
      end
    end
    step();
    mack = 0;
    check("s_dvalid", {31'd0, dvalid}, 1);
    check("s_rd_kept", rd, 32'hAA);
    check("s_mwe_off", {31'd0, mwe}, 0);
    check("s_berr", {31'd0, berr}, 0);
    idle_inputs();
    step();

    // load timeout
    moe = 1; addr = 32'h300; mdin = 32'h55;
    exp_q.push_back(32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t_mre_wait", {31'd0, mre}, 1);
      check("t_berr_wait", {31'd0, berr}, 0);
    end
    step();
    check("t_dvalid", {31'd0, dvalid}, 1);
    check("t_rd_zero", rd, 0);
    check("t_berr", {31'd0, berr}, 1);
    check("t_mre_off", {31'd0, mre}, 0);
    moe = 0;
    step();
    check("t_berr_once", {31'd0, berr}, 0);
    check("t_dvalid_clr", {31'd0, dvalid}, 0);

    // mack on the timeout edge wins
    moe = 1; addr = 32'h304;
    exp_q.push_back(32'h5A5A);
    step();
    step();
    step();
    mack = 1; mdin = 32'h5A5A;
    step();
    mack = 0;
    check("ta_dvalid", {31'd0, dvalid}, 1);
    check("ta_rd", rd, 32'h5A5A);
    check("ta_no_berr", {31'd0, berr}, 0);
    moe = 0;
    step();
    check("ta_no_berr2", {31'd0, berr}, 0);

    // stalled pipeline: data result held 5 cycles while a slow fetch completes
    x1 = $urandom_range(32'h7FFFFFFF, 1);
    x2 = $urandom_range(32'h7FFFFFFF, 1);
    moe = 1; addr = 32'h400; ireq = 1; iaddr = 32'h48;
    exp_q.push_back(x1);
    exp_q.push_back(x2);
    step();
    mack = 1; mdin = x1;
    step();
    mack = 0;
    check("n_dvalid", {31'd0, dvalid}, 1);
    step();
    check("n_ma_inst", ma, 32'h48);
    step();
    step();
    mack = 1; mdin = x2;
    step();
    mack = 0;
    check("n_flags", {30'd0, ivalid, dvalid}, 2'b11);
    check("n_stall", {31'd0, stall}, 0);
    idle_inputs();
    step();
    check("n_single_issue", data_issues, 1);

    // fetch timeout
    ireq = 1; iaddr = 32'h80;
    exp_q.push_back(32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ft_berr_wait", {31'd0, berr}, 0);
    end
    step();
    check("ft_ivalid", {31'd0, ivalid}, 1);
    check("ft_idata_zero", idata, 0);
    check("ft_berr", {31'd0, berr}, 1);
    ireq = 0;
    step();
    check("ft_berr_once", {31'd0, berr}, 0);

    step();
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
